// File: rtl/shift_pkg.sv
// Shared types and defaults for the iterative shifter.
package shift_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_STEP  = 8;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } shifter_state_t;
endpackage

// File: rtl/shift_step.sv
// One bounded shift/rotate step (distance 0..STEP) with ARM-style carry-out.
// The rotate path exists only when ITERATIVE_SHIFTER_ROR_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = DEFAULT_STEP,
  localparam int DW   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [DW-1:0]    i_dist,
  input  logic [1:0]       i_type,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry
);
  logic [DW-1:0]    w_dm1;
  logic [WIDTH-1:0] w_lpre, w_rpre, w_fill;

  // Shifting by one less than the distance puts the last bit out at the edge.
  assign w_dm1  = i_dist - DW'(1);
  assign w_lpre = i_data << w_dm1;
  assign w_rpre = i_data >> w_dm1;
  assign w_fill = i_sign ? ~({WIDTH{1'b1}} >> i_dist) : '0;

`ifdef ITERATIVE_SHIFTER_ROR_EN
  localparam int AW = $clog2(WIDTH) + 1;
  logic [AW-1:0]    w_ldist;
  logic [WIDTH-1:0] w_rot;
  assign w_ldist = AW'(WIDTH) - AW'(i_dist);
  assign w_rot   = (i_data >> i_dist) | (i_data << w_ldist);
`endif

  always_comb begin
    o_data  = i_data;
    o_carry = 1'b0;
    case (shift_type_t'(i_type))
      SHIFT_LSL: begin o_data = i_data << i_dist;          o_carry = w_lpre[WIDTH-1]; end
      SHIFT_LSR: begin o_data = i_data >> i_dist;          o_carry = w_rpre[0];       end
      SHIFT_ASR: begin o_data = (i_data >> i_dist) | w_fill; o_carry = w_rpre[0];     end
`ifdef ITERATIVE_SHIFTER_ROR_EN
      SHIFT_ROR: begin o_data = w_rot;                     o_carry = w_rot[WIDTH-1];  end
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: up to STEP bits per clock behind valid/ready handshakes.
// Define ITERATIVE_SHIFTER_ROR_EN to enable ROR; otherwise type 11 passes through.
module iterative_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STEP   = DEFAULT_STEP,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic [1:0]       in_type,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);
  localparam int DW = $clog2(STEP) + 1;
  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

  shifter_state_t   r_state, w_next;
  logic [WIDTH-1:0] r_work, r_out_data, w_sh_data;
  logic [AMT_W-1:0] r_rem, w_rem_nxt;
  logic [1:0]       r_type;
  logic             r_sign, r_out_carry, w_sh_carry;
  logic             w_accept, w_bypass;
  logic [DW-1:0]    w_step;

  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_step    = (r_rem > STEP_A) ? DW'(STEP) : DW'(r_rem);
  assign w_rem_nxt = r_rem - AMT_W'(w_step);

`ifdef ITERATIVE_SHIFTER_ROR_EN
  assign w_bypass = (in_amount == '0);
`else
  assign w_bypass = (in_amount == '0) || (in_type == SHIFT_ROR);
`endif

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .i_data  (r_work),
    .i_dist  (w_step),
    .i_type  (r_type),
    .i_sign  (r_sign),
    .o_data  (w_sh_data),
    .o_carry (w_sh_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = w_bypass ? DONE : BUSY;
      BUSY:    if (w_rem_nxt == '0) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Result registers load only on entry to DONE, so a flush leaves the last result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work      <= '0;
      r_rem       <= '0;
      r_type      <= '0;
      r_sign      <= 1'b0;
      r_out_data  <= '0;
      r_out_carry <= 1'b0;
    end else if (!flush) begin
      if (w_accept) begin
        r_work <= in_data;
        r_rem  <= in_amount;
        r_type <= in_type;
        r_sign <= in_data[WIDTH-1];
        if (w_bypass) begin
          r_out_data  <= in_data;
          r_out_carry <= in_carry;
        end
      end else if (r_state == BUSY) begin
        r_work <= w_sh_data;
        r_rem  <= w_rem_nxt;
        if (w_rem_nxt == '0) begin
          r_out_data  <= w_sh_data;
          r_out_carry <= w_sh_carry;
        end
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_carry = r_out_carry;
endmodule

// File: tb/tb_iterative_shifter.sv
// Directed bench for iterative_shifter (WIDTH 32, STEP 8); ROR expectations follow ITERATIVE_SHIFTER_ROR_EN.
module tb_iterative_shifter;
  localparam int WIDTH = 32;
  localparam int STEP  = 8;

  logic        clk, rst_n, flush, in_valid, in_ready, in_carry;
  logic        out_valid, out_ready, out_carry;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_amount;
  logic [1:0]  in_type;

  int errors = 0;
  int checks = 0;

  iterative_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_type   (in_type),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, scramble the inputs after accept, wait for out_valid and pop it.
  // lat counts rising edges from the accept edge (inclusive) until out_valid is seen.
  task automatic run_op(input logic [1:0] t, input logic [31:0] d, input logic [4:0] a,
                        input logic c, output logic [31:0] od, output logic oc, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_type = t; in_data = d; in_amount = a; in_carry = c;
    @(posedge clk); #1;
    in_valid = 1'b0; in_type = ~t; in_data = ~d; in_amount = 5'd3; in_carry = ~c;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    od = out_data; oc = out_carry;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0)  begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_carry !== 1'b0)  begin errors++; $display("FAIL reset_out_carry got=%b exp=0", out_carry); end
  endtask

  task automatic test_lsl();
    logic [31:0] vd[3], vr[3];
    logic [4:0]  va[3];
    logic        vc[3];
    int          vl[3];
    logic [31:0] od; logic oc; int lat;
    vd = '{32'h0000_0001, 32'h0080_0001, 32'hF000_0001};
    va = '{5'd31, 5'd9, 5'd4};
    vr = '{32'h8000_0000, 32'h0000_0200, 32'h0000_0010};
    vc = '{1'b0, 1'b1, 1'b1};
    vl = '{5, 3, 2};
    for (int i = 0; i < 3; i++) begin
      run_op(2'b00, vd[i], va[i], 1'b0, od, oc, lat);
      checks++; if (od !== vr[i])  begin errors++; $display("FAIL lsl%0d_data got=%h exp=%h", i, od, vr[i]); end
      checks++; if (oc !== vc[i])  begin errors++; $display("FAIL lsl%0d_carry got=%b exp=%b", i, oc, vc[i]); end
      checks++; if (lat !== vl[i]) begin errors++; $display("FAIL lsl%0d_latency got=%0d exp=%0d", i, lat, vl[i]); end
    end
  endtask

  task automatic test_lsr();
    logic [31:0] vd[3], vr[3];
    logic [4:0]  va[3];
    logic        vc[3];
    int          vl[3];
    logic [31:0] od; logic oc; int lat;
    vd = '{32'h0000_00F1, 32'hFFFF_FFFF, 32'h0000_0100};
    va = '{5'd1, 5'd16, 5'd9};
    vr = '{32'h0000_0078, 32'h0000_FFFF, 32'h0000_0000};
    vc = '{1'b1, 1'b1, 1'b1};
    vl = '{2, 3, 3};
    for (int i = 0; i < 3; i++) begin
      run_op(2'b01, vd[i], va[i], 1'b0, od, oc, lat);
      checks++; if (od !== vr[i])  begin errors++; $display("FAIL lsr%0d_data got=%h exp=%h", i, od, vr[i]); end
      checks++; if (oc !== vc[i])  begin errors++; $display("FAIL lsr%0d_carry got=%b exp=%b", i, oc, vc[i]); end
      checks++; if (lat !== vl[i]) begin errors++; $display("FAIL lsr%0d_latency got=%0d exp=%0d", i, lat, vl[i]); end
    end
  endtask

  task automatic test_asr();
    logic [31:0] vd[4], vr[4];
    logic [4:0]  va[4];
    logic        vc[4];
    int          vl[4];
    logic [31:0] od; logic oc; int lat;
    vd = '{32'h8000_0000, 32'h8000_000F, 32'h8000_0000, 32'h7000_0000};
    va = '{5'd4, 5'd1, 5'd20, 5'd20};
    vr = '{32'hF800_0000, 32'hC000_0007, 32'hFFFF_F800, 32'h0000_0700};
    vc = '{1'b0, 1'b1, 1'b0, 1'b0};
    vl = '{2, 2, 4, 4};
    for (int i = 0; i < 4; i++) begin
      run_op(2'b10, vd[i], va[i], 1'b1, od, oc, lat);
      checks++; if (od !== vr[i])  begin errors++; $display("FAIL asr%0d_data got=%h exp=%h", i, od, vr[i]); end
      checks++; if (oc !== vc[i])  begin errors++; $display("FAIL asr%0d_carry got=%b exp=%b", i, oc, vc[i]); end
      checks++; if (lat !== vl[i]) begin errors++; $display("FAIL asr%0d_latency got=%0d exp=%0d", i, lat, vl[i]); end
    end
  endtask

  task automatic test_ror();
    logic [31:0] vd[3], vr[3];
    logic [4:0]  va[3];
    logic        vci[3], vc[3];
    int          vl[3];
    logic [31:0] od; logic oc; int lat;
    vd  = '{32'h0000_0001, 32'h0000_0080, 32'h0000_0ABC};
    va  = '{5'd8, 5'd8, 5'd12};
    vci = '{1'b1, 1'b0, 1'b1};
`ifdef ITERATIVE_SHIFTER_ROR_EN
    vr = '{32'h0100_0000, 32'h8000_0000, 32'hABC0_0000};
    vc = '{1'b0, 1'b1, 1'b1};
    vl = '{2, 2, 3};
`else
    vr = vd;
    vc = vci;
    vl = '{1, 1, 1};
`endif
    for (int i = 0; i < 3; i++) begin
      run_op(2'b11, vd[i], va[i], vci[i], od, oc, lat);
      checks++; if (od !== vr[i])  begin errors++; $display("FAIL ror%0d_data got=%h exp=%h", i, od, vr[i]); end
      checks++; if (oc !== vc[i])  begin errors++; $display("FAIL ror%0d_carry got=%b exp=%b", i, oc, vc[i]); end
      checks++; if (lat !== vl[i]) begin errors++; $display("FAIL ror%0d_latency got=%0d exp=%0d", i, lat, vl[i]); end
    end
  endtask

  task automatic test_amount_zero_hold();
    logic [31:0] od; logic oc; int lat;
    run_op(2'b10, 32'h8000_0001, 5'd0, 1'b0, od, oc, lat);
    checks++; if (od !== 32'h8000_0001) begin errors++; $display("FAIL zero_asr_data got=%h exp=80000001", od); end
    checks++; if (oc !== 1'b0)          begin errors++; $display("FAIL zero_asr_carry got=%b exp=0", oc); end
    checks++; if (lat !== 1)            begin errors++; $display("FAIL zero_asr_latency got=%0d exp=1", lat); end

    @(negedge clk);
    in_valid = 1'b1; in_type = 2'b00; in_data = 32'hDEAD_BEEF; in_amount = 5'd0; in_carry = 1'b1;
    @(posedge clk); #1;
    in_data = 32'h1234_5678; in_carry = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_latency got=%b exp=1", out_valid); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hold%0d_data got=%h exp=deadbeef", i, out_data); end
      checks++; if (out_carry !== 1'b1)         begin errors++; $display("FAIL hold%0d_carry got=%b exp=1", i, out_carry); end
      checks++; if (out_valid !== 1'b1)         begin errors++; $display("FAIL hold%0d_valid got=%b exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0)          begin errors++; $display("FAIL hold%0d_in_ready got=%b exp=0", i, in_ready); end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL pop_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_out_valid got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'hDEAD_BEEF)
      begin errors++; $display("FAIL second_req_dropped got=%b/%h exp=0/deadbeef", out_valid, out_data); end
  endtask

  task automatic test_flush();
    logic [31:0] od; logic oc; int lat;
    logic        seen;
    run_op(2'b01, 32'hFFFF_FFFF, 5'd16, 1'b0, od, oc, lat);
    @(negedge clk);
    in_valid = 1'b1; in_type = 2'b00; in_data = 32'h0000_0001; in_amount = 5'd24; in_carry = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    @(negedge clk); flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0)             begin errors++; $display("FAIL flush_no_result got=%b exp=0", seen); end
    checks++; if (out_data !== 32'h0000_FFFF) begin errors++; $display("FAIL flush_keep_data got=%h exp=0000ffff", out_data); end
    checks++; if (out_carry !== 1'b1)        begin errors++; $display("FAIL flush_keep_carry got=%b exp=1", out_carry); end

    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h5555_AAAA; in_amount = 5'd0; in_carry = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL flush_idle_accept got=%b/%b exp=1/0", in_ready, out_valid); end
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] od; logic oc; int lat;
    @(negedge clk);
    in_valid = 1'b1; in_type = 2'b00; in_data = 32'h0000_0001; in_amount = 5'd24; in_carry = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== 32'h0)  begin errors++; $display("FAIL rst_mid_out_data got=%h exp=0", out_data); end
    @(negedge clk); rst_n = 1'b1;
    run_op(2'b10, 32'h8000_000F, 5'd1, 1'b0, od, oc, lat);
    checks++; if (od !== 32'hC000_0007 || oc !== 1'b1 || lat !== 2)
      begin errors++; $display("FAIL after_reset_op got=%h/%b/%0d exp=c0000007/1/2", od, oc, lat); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_amount = '0; in_type = '0; in_carry = 1'b0;
    #1;
    test_reset();
    #14 rst_n = 1'b1;
    test_lsl();
    test_lsr();
    test_asr();
    test_ror();
    test_amount_zero_hold();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
Multi-cycle, parametrised successor to the combinational datapath shifter. It shifts or rotates a WIDTH-bit operand by up to STEP bits per clock, runs a small FSM, and returns the last bit shifted out as an ARM-style carry. It sits in the processor execute stage behind a valid/ready handshake, so large shifts can be traded for cycles without a full barrel network.

Parameters:
WIDTH, 32, operand/result width in bits; power of two, at least 8
STEP, 8, maximum shift distance applied per cycle; power of two, 1..WIDTH/2
AMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort; return to IDLE
in_valid  input  1  request valid
in_ready  output  1  shifter can accept a request
in_data  input  WIDTH  operand to shift
in_amount  input  AMT_W  shift distance, 0..WIDTH-1
in_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
in_carry  input  1  carry flag passed through when amount is 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  shifted result
out_carry  output  1  last bit shifted out

Behaviour:
- One clock. Reset is asynchronous and active-low (clk, rst_n).
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded from state only.
- Reset values: state IDLE, out_data 0, out_carry 0, internal remaining-count 0. out_valid reads 0 and in_ready reads 1 while in reset.
- IDLE, on in_valid & in_ready:
  - latch data, amount, type and carry into working registers;
  - amount == 0 -> DONE;
  - otherwise -> BUSY with remaining = amount.
- BUSY, each cycle:
  - step = min(remaining, STEP);
  - apply a step-bit shift of the latched type to the working register;
  - carry = last bit shifted out of this step;
  - remaining -= step;
  - remaining reaching 0 -> DONE.
- Shift rules by type:
  - LSL: zero fill; carry = bit WIDTH-step before the step.
  - LSR: zero fill; carry = bit step-1 before the step.
  - ASR: fill with the original sign bit; carry = bit step-1 before the step.
  - ROR: rotate right; carry = result bit WIDTH-1 after the step.
- Amount 0 (any type): out_data = in_data, out_carry = in_carry.
- Latency from the accept edge to out_valid high: 1 + ceil(amount/STEP) cycles. Amount 0 gives 1 cycle.
- DONE: out_data and out_carry are held stable until out_valid & out_ready. Then -> IDLE. There is no back-to-back accept in the same cycle, so in_ready is 0 in DONE.
- flush has priority over every transition:
  - next state IDLE, any pending result dropped;
  - out_data and out_carry keep their last values;
  - flush in IDLE coincident with in_valid: the request is not accepted.
- in_type, in_data and in_amount are ignored outside the accept cycle; changes while BUSY have no effect.
- Reset asserted mid-BUSY or mid-DONE: immediate return to reset values; the in-flight request is lost.

Optional Feature:
ITERATIVE_SHIFTER_ROR_EN
- Defined: type 11 performs ROR as above.
- Undefined: type 11 is a pass-through. out_data = in_data, out_carry = in_carry, latency 1 cycle regardless of amount. The rotate mux is not synthesised.

Decomposition:
- Package shift_pkg:
  - shift_type_t enum (SHIFT_LSL = 2'b00, SHIFT_LSR = 2'b01, SHIFT_ASR = 2'b10, SHIFT_ROR = 2'b11);
  - shifter_state_t enum (IDLE, BUSY, DONE);
  - DEFAULT_WIDTH = 32 and DEFAULT_STEP = 8 constants.
- One sub-module: shift_step. Combinational, parametrised by WIDTH and STEP. Inputs: data, step distance (0..STEP), type, sign. Outputs: shifted data and carry. Instantiated once inside the BUSY datapath.

Test Plan:
1. LSL 0x0000_0001 by 31 -> out_data 0x8000_0000, out_carry 0; out_valid 5 cycles after accept (4 BUSY cycles at STEP 8).
2. ASR 0x8000_0000 by 4 -> 0xF800_0000, out_carry 0, latency 2. ASR 0x8000_000F by 1 -> 0xC000_0007, out_carry 1.
3. LSR 0x0000_00F1 by 1 -> 0x0000_0078, out_carry 1. LSR 0xFFFF_FFFF by 16 -> 0x0000_FFFF, out_carry 1, latency 3.
4. ROR 0x0000_0001 by 8 with macro defined -> 0x0100_0000, out_carry 0. ROR 0x0000_0080 by 8 -> 0x8000_0000, out_carry 1. Without the macro: 0x0000_0001 by 8 -> 0x0000_0001, out_carry = in_carry, latency 1.
5. Amount 0, in_carry 1, data 0xDEAD_BEEF -> same data, carry 1 after 1 cycle. Hold out_ready low 3 cycles -> outputs stable, in_ready 0, a second in_valid is not accepted.
6. Start LSL by 24, then pulse flush in 2nd BUSY cycle -> IDLE next cycle, out_valid never rises. Repeat with rst_n low mid-BUSY -> out_valid 0 and in_ready 1 immediately, out_data 0.
